// File: rtl/alu_seq.sv
// alu_seq -- EX-stage ALU for the multi-cycle MIPS core.
//
// Single-cycle ops (add/sub/logic/compare/shift/lui) are registered and
// can be issued back to back, giving one result per cycle. mult/multu and
// div/divu run an iterative one-bit-per-cycle datapath and hold in_ready
// low until the result has been written to HI/LO.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   request handshake; in_ready == (state == IDLE)
//   alu_op, alu_a/b     opcode and operands (rs, rt/imm)
//   out_valid           one-cycle pulse: out_result and flags are valid
//   out_result          result (LO for mul/div)
//   out_zero            zero / branch-condition flag
//   out_ovf, out_dbz    signed overflow, divide by zero
//   hi, lo              architectural HI/LO registers
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             out_dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int               MSB     = WIDTH - 1;
    localparam int               SH_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_MULT  = 4'b0011;
    localparam logic [3:0] OP_MULTU = 4'b0100;
    localparam logic [3:0] OP_DIV   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_BNE   = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_SLTU  = 4'b1010;
    localparam logic [3:0] OP_XOR   = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_SRA   = 4'b1101;
    localparam logic [3:0] OP_BGEZ  = 4'b1110;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    // Everything the iterative ops need after the operands are gone.
    typedef struct packed {
        logic [WIDTH-1:0] mag_b;   // |multiplicand| or |divisor|
        logic             neg_q;   // negate product / quotient at the end
        logic             neg_r;   // negate remainder (dividend was negative)
        logic             ovf;     // signed MIN / -1
        logic             dbz;     // divisor was zero: skip iteration
        logic             is_div;
    } iter_req_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    iter_req_t        req_r;
    logic [WIDTH:0]   acc;     // product high half / partial remainder
    logic [WIDTH-1:0] qr;      // multiplier shifting out / quotient shifting in

    logic accept;
    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH-1:0] sum, diff, sc_res;
    logic             sc_zero, sc_ovf;

    assign sum  = alu_a + alu_b;
    assign diff = alu_a - alu_b;

    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        case (alu_op)
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (alu_a[MSB] == alu_b[MSB]) && (sum[MSB] != alu_a[MSB]);
            end
            OP_SUB, OP_BNE: begin
                sc_res = diff;
                sc_ovf = (alu_a[MSB] != alu_b[MSB]) && (diff[MSB] != alu_a[MSB]);
            end
            OP_AND:  sc_res = alu_a & alu_b;
            OP_OR:   sc_res = alu_a | alu_b;
            OP_NOR:  sc_res = ~(alu_a | alu_b);
            OP_XOR:  sc_res = alu_a ^ alu_b;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, alu_a < alu_b};
            OP_BGEZ: sc_res = {{(WIDTH-1){1'b0}}, ~alu_a[MSB]};
            OP_LUI:  sc_res = alu_b << (WIDTH / 2);
            OP_SRA:  sc_res = $unsigned($signed(alu_b) >>> alu_a[SH_W-1:0]);
            default: sc_res = '0;
        endcase

        sc_zero = (sc_res == '0);
        if (alu_op == OP_BNE)  sc_zero = (sc_res != '0);
        if (alu_op == OP_BGEZ) sc_zero = ~alu_a[MSB];
    end

    // ---------------- mul/div issue ----------------
    logic             is_mul_op, is_div_op, is_sgn_op, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign is_mul_op = (alu_op == OP_MULT) || (alu_op == OP_MULTU);
    assign is_div_op = (alu_op == OP_DIV)  || (alu_op == OP_DIVU);
    assign is_sgn_op = (alu_op == OP_MULT) || (alu_op == OP_DIV);
    assign a_neg     = is_sgn_op && alu_a[MSB];
    assign b_neg     = is_sgn_op && alu_b[MSB];
    // MIN maps onto itself, which read as unsigned is the right magnitude.
    assign mag_a     = a_neg ? -alu_a : alu_a;
    assign mag_b     = b_neg ? -alu_b : alu_b;

    // ---------------- iteration steps ----------------
    // Shift-add: add multiplicand when the multiplier LSB is set, then shift
    // {acc,qr} right. The extra acc bit catches the add carry.
    logic [WIDTH:0] mul_add;
    assign mul_add = qr[0] ? (acc + {1'b0, req_r.mag_b}) : acc;

    // Restoring division: bring the next dividend bit into the remainder and
    // keep the trial subtraction only if it does not go negative.
    logic [WIDTH:0] div_sh, div_trial;
    logic           div_ge;
    assign div_sh    = {acc[WIDTH-1:0], qr[MSB]};
    assign div_ge    = (div_sh >= {1'b0, req_r.mag_b});
    assign div_trial = div_sh - {1'b0, req_r.mag_b};

    // ---------------- sign fix-up ----------------
    logic [2*WIDTH-1:0] prod, prod_f;
    logic [WIDTH-1:0]   quot_f, rem_f;
    assign prod   = {acc[WIDTH-1:0], qr};
    assign prod_f = req_r.neg_q ? -prod : prod;
    assign quot_f = req_r.neg_q ? -qr : qr;
    assign rem_f  = req_r.neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

    // ---------------- FSM + registered outputs ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            req_r      <= '0;
            acc        <= '0;
            qr         <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_ovf    <= 1'b0;
            out_dbz    <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mul_op || is_div_op) begin
                            req_r.mag_b  <= mag_b;
                            req_r.neg_q  <= a_neg ^ b_neg;
                            req_r.neg_r  <= a_neg;
                            req_r.ovf    <= is_sgn_op && is_div_op &&
                                            (alu_a == MIN_VAL) && (alu_b == '1);
                            req_r.dbz    <= is_div_op && (alu_b == '0);
                            req_r.is_div <= is_div_op;
                            cnt          <= '0;
                            acc          <= '0;
                            qr           <= mag_a;
                            state        <= is_mul_op ? MUL : DIV;
                        end else begin
                            out_valid  <= 1'b1;
                            out_result <= sc_res;
                            out_zero   <= sc_zero;
                            out_ovf    <= sc_ovf;
                            out_dbz    <= 1'b0;
                        end
                    end
                end
                MUL: begin
                    acc <= {1'b0, mul_add[WIDTH:1]};
                    qr  <= {mul_add[0], qr[MSB:1]};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) state <= DONE;
                end
                DIV: begin
                    if (req_r.dbz) begin
                        state <= DONE;
                    end else begin
                        acc <= div_ge ? div_trial : div_sh;
                        qr  <= {qr[MSB-1:0], div_ge};
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST) state <= DONE;
                    end
                end
                DONE: begin
                    out_valid <= 1'b1;
                    state     <= IDLE;
                    if (req_r.dbz) begin
                        // HI/LO untouched; report the old LO.
                        out_result <= lo;
                        out_zero   <= (lo == '0);
                        out_ovf    <= 1'b0;
                        out_dbz    <= 1'b1;
                    end else if (req_r.is_div) begin
                        hi         <= rem_f;
                        lo         <= quot_f;
                        out_result <= quot_f;
                        out_zero   <= (quot_f == '0);
                        out_ovf    <= req_r.ovf;
                        out_dbz    <= 1'b0;
                    end else begin
                        hi         <= prod_f[2*WIDTH-1:WIDTH];
                        lo         <= prod_f[WIDTH-1:0];
                        out_result <= prod_f[WIDTH-1:0];
                        out_zero   <= (prod_f[WIDTH-1:0] == '0);
                        out_ovf    <= 1'b0;
                        out_dbz    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
